// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RISC core: steps the datapath IF/ID/EX/MEM/WB one micro-step per clock.
// Outputs decode the registered state and current opcode combinationally; only the state is stored.
module multicycle_controller (
    input  logic       clk,
    input  logic       Rst,
    input  logic [4:0] opcode,
    input  logic [1:0] ALUopcode,
    input  logic [2:0] PSW_NZC,
    output logic       Buff_PC,
    output logic       Buff_MEMIns,
    output logic       Buff_PSW,
    output logic       WE_MEM,
    output logic       WE_RF,
    output logic       MEMresource,
    output logic       RBresource,
    output logic       WBresource,
    output logic       PCplus1orWB,
    output logic       oprandB,
    output logic       LI,
    output logic       ALUop,
    output logic       Flag,
    output logic       LIorMOV,
    output logic       ALUorNot,
    output logic       Branch,
    output logic [1:0] Jump,
    output logic [2:0] state,
    output logic       halted,
    output logic       illegal
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    localparam logic [4:0] OP_ALU  = 5'b00000;
    localparam logic [4:0] OP_ALUI = 5'b00001;
    localparam logic [4:0] OP_LI   = 5'b00010;
    localparam logic [4:0] OP_LHI  = 5'b00011;
    localparam logic [4:0] OP_MOV  = 5'b00100;
    localparam logic [4:0] OP_LD   = 5'b00101;
    localparam logic [4:0] OP_ST   = 5'b00110;
    localparam logic [4:0] OP_B    = 5'b00111;
    localparam logic [4:0] OP_JMP  = 5'b01000;
    localparam logic [4:0] OP_JAL  = 5'b01001;
    localparam logic [4:0] OP_JR   = 5'b01010;
    localparam logic [4:0] OP_HLT  = 5'b11111;

    state_t cur;
    logic   is_legal;
    logic   is_ctl;
    logic   is_mem;
    logic   uses_imm;
    logic   taken;

    assign is_legal = (opcode <= OP_JR) || (opcode == OP_HLT);
    assign is_ctl   = (opcode == OP_B) || (opcode == OP_JMP) || (opcode == OP_JR);
    assign is_mem   = (opcode == OP_LD) || (opcode == OP_ST);
    assign uses_imm = (opcode == OP_ALUI) || is_mem;

    // Branch condition looks at the live PSW so a B right after an ALU sees fresh flags.
    always_comb begin
        taken = 1'b0;
        case (ALUopcode)
            2'b00: taken = 1'b1;
            2'b01: taken = PSW_NZC[1];
            2'b10: taken = PSW_NZC[2];
            2'b11: taken = PSW_NZC[0];
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!Rst) begin
            cur <= S_IF;
        end else begin
            case (cur)
                S_IF:   cur <= S_ID;
                S_ID: begin
                    if (!is_legal)             cur <= S_IF;
                    else if (opcode == OP_HLT) cur <= S_HALT;
                    else                       cur <= S_EX;
                end
                S_EX: begin
                    if (is_ctl)      cur <= S_IF;
                    else if (is_mem) cur <= S_MEM;
                    else             cur <= S_WB;
                end
                S_MEM:  cur <= (opcode == OP_LD) ? S_WB : S_IF;
                S_WB:   cur <= S_IF;
                S_HALT: cur <= S_HALT;
                default: cur <= S_IF;
            endcase
        end
    end

    assign state = cur;

    always_comb begin
        Buff_PC     = 1'b0;
        Buff_MEMIns = 1'b0;
        Buff_PSW    = 1'b0;
        WE_MEM      = 1'b0;
        WE_RF       = 1'b0;
        MEMresource = 1'b0;
        RBresource  = 1'b0;
        WBresource  = 1'b0;
        PCplus1orWB = 1'b0;
        oprandB     = 1'b0;
        LI          = 1'b0;
        ALUop       = 1'b0;
        Flag        = 1'b0;
        LIorMOV     = 1'b0;
        ALUorNot    = 1'b0;
        Branch      = 1'b0;
        Jump        = 2'b00;
        halted      = 1'b0;
        illegal     = 1'b0;
        case (cur)
            S_IF: Buff_MEMIns = 1'b1;
            S_ID: begin
                RBresource = (opcode == OP_ST);
                oprandB    = uses_imm;
                // Undefined opcodes skip ahead with a plain PC+1.
                illegal    = !is_legal;
                Buff_PC    = !is_legal;
            end
            S_EX: begin
                ALUop    = (opcode == OP_ALU) || (opcode == OP_ALUI) || is_mem;
                oprandB  = uses_imm;
                Flag     = (opcode == OP_ALU) || (opcode == OP_ALUI);
                Buff_PSW = (opcode == OP_ALU) || (opcode == OP_ALUI);
                Buff_PC  = is_ctl;
                Branch   = (opcode == OP_B) && taken;
                if (opcode == OP_JMP)     Jump = 2'b01;
                else if (opcode == OP_JR) Jump = 2'b11;
            end
            S_MEM: begin
                MEMresource = 1'b1;
                WE_MEM      = (opcode == OP_ST);
                Buff_PC     = (opcode == OP_ST);
            end
            S_WB: begin
                WE_RF       = 1'b1;
                Buff_PC     = 1'b1;
                ALUorNot    = (opcode == OP_ALU) || (opcode == OP_ALUI);
                WBresource  = (opcode == OP_LD);
                LIorMOV     = (opcode == OP_LI) || (opcode == OP_LHI);
                LI          = (opcode == OP_LHI);
                PCplus1orWB = (opcode == OP_JAL);
                if (opcode == OP_JAL) Jump = 2'b10;
            end
            S_HALT: halted = 1'b1;
            default: Buff_MEMIns = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: stimulus pushes per-cycle expectations from a reference model,
// an independent monitor pops one expectation per cycle and compares all outputs.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       Rst;
    logic [4:0] opcode;
    logic [1:0] ALUopcode;
    logic [2:0] PSW_NZC;
    logic       Buff_PC, Buff_MEMIns, Buff_PSW, WE_MEM, WE_RF;
    logic       MEMresource, RBresource, WBresource, PCplus1orWB, oprandB;
    logic       LI, ALUop, Flag, LIorMOV, ALUorNot, Branch;
    logic [1:0] Jump;
    logic [2:0] state;
    logic       halted, illegal;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .Rst(Rst), .opcode(opcode), .ALUopcode(ALUopcode), .PSW_NZC(PSW_NZC),
        .Buff_PC(Buff_PC), .Buff_MEMIns(Buff_MEMIns), .Buff_PSW(Buff_PSW), .WE_MEM(WE_MEM),
        .WE_RF(WE_RF), .MEMresource(MEMresource), .RBresource(RBresource), .WBresource(WBresource),
        .PCplus1orWB(PCplus1orWB), .oprandB(oprandB), .LI(LI), .ALUop(ALUop), .Flag(Flag),
        .LIorMOV(LIorMOV), .ALUorNot(ALUorNot), .Branch(Branch), .Jump(Jump), .state(state),
        .halted(halted), .illegal(illegal)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       halted, illegal, buff_pc, buff_memins, buff_psw, we_mem, we_rf;
        logic       memres, rbres, wbres, pcp1, oprb, li, aluop, flag, liormov, aluornot, branch;
        logic [1:0] jump;
    } obs_t;

    localparam logic [4:0] ALU = 5'd0, ALUI = 5'd1, LIO = 5'd2, LHI = 5'd3, MOV = 5'd4, LD = 5'd5;
    localparam logic [4:0] ST = 5'd6, BR = 5'd7, JMP = 5'd8, JAL = 5'd9, JR = 5'd10, HLT = 5'd31;

    obs_t got;
    assign got = {state, halted, illegal, Buff_PC, Buff_MEMIns, Buff_PSW, WE_MEM, WE_RF,
                  MEMresource, RBresource, WBresource, PCplus1orWB, oprandB, LI, ALUop, Flag,
                  LIorMOV, ALUorNot, Branch, Jump};

    obs_t expq[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic legal_op(input logic [4:0] op);
        return (op <= JR) || (op == HLT);
    endfunction

    // Number of cycles each instruction spends before the next IF (HLT counted up to HALT entry).
    function automatic int seq_len(input logic [4:0] op);
        if (!legal_op(op) || op == HLT) return 2;
        if (op == LD) return 5;
        if (op == BR || op == JMP || op == JR) return 3;
        return 4;
    endfunction

    function automatic obs_t model(input logic [4:0] op, input logic [1:0] fn,
                                   input logic [2:0] nzc, input int k);
        obs_t o = '0;
        int   st;
        logic cond;
        if (k == 0)                           st = 0;
        else if (k == 1)                      st = 1;
        else if (op == HLT)                   st = 5;
        else if (k == 2)                      st = 2;
        else if (k == 3 && (op == LD || op == ST)) st = 3;
        else                                  st = 4;
        cond = (fn == 2'd0) || (fn == 2'd1 && nzc[1]) || (fn == 2'd2 && nzc[2]) || (fn == 2'd3 && nzc[0]);
        o.st = st[2:0];
        // The instruction's last step is where the PC moves.
        o.buff_pc = (op != HLT) && (k == seq_len(op) - 1);
        case (st)
            0: o.buff_memins = 1'b1;
            1: begin
                o.rbres   = (op == ST);
                o.oprb    = (op == ALUI || op == LD || op == ST);
                o.illegal = !legal_op(op);
            end
            2: begin
                o.aluop    = (op == ALU || op == ALUI || op == LD || op == ST);
                o.oprb     = (op == ALUI || op == LD || op == ST);
                o.flag     = (op == ALU || op == ALUI);
                o.buff_psw = o.flag;
                o.branch   = (op == BR) && cond;
                o.jump     = (op == JMP) ? 2'b01 : (op == JR) ? 2'b11 : 2'b00;
            end
            3: begin
                o.memres = 1'b1;
                o.we_mem = (op == ST);
            end
            4: begin
                o.we_rf    = 1'b1;
                o.aluornot = (op == ALU || op == ALUI);
                o.wbres    = (op == LD);
                o.liormov  = (op == LIO || op == LHI);
                o.li       = (op == LHI);
                o.pcp1     = (op == JAL);
                o.jump     = (op == JAL) ? 2'b10 : 2'b00;
            end
            default: o.halted = 1'b1;
        endcase
        return o;
    endfunction

    // Monitor: one expectation per cycle, sampled mid-cycle.
    obs_t e;
    initial begin
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                total++;
                if (got !== e) begin
                    bad++;
                    $display("FAIL outputs t=%0t: got=%b want=%b", $time, got, e);
                end
                total++;
                if ($countones({WE_RF, WE_MEM, Buff_PSW}) > 1) begin
                    bad++;
                    $display("FAIL exclusive_we t=%0t: got=%b want at most one set", $time,
                             {WE_RF, WE_MEM, Buff_PSW});
                end
            end
        end
    end

    // Called just after a posedge with the DUT in IF; returns just after the posedge entering the next IF.
    task automatic run_instr(input logic [4:0] op, input logic [1:0] fn, input logic [2:0] nzc,
                             input int abort_at, input int halt_cycles);
        int n;
        n = (op == HLT) ? 2 + halt_cycles : seq_len(op);
        for (int k = 0; k < n; k++) begin
            opcode    = op;
            ALUopcode = fn;
            PSW_NZC   = nzc;
            expq.push_back(model(op, fn, nzc, k));
            if (k == abort_at) Rst = 1'b0;
            @(posedge clk);
            #1;
            if (!Rst) begin
                Rst = 1'b1;
                break;
            end
        end
    endtask

    logic [4:0] rop;
    int         ab, hc;

    initial begin
        Rst       = 1'b0;
        opcode    = HLT;
        ALUopcode = 2'd0;
        PSW_NZC   = 3'd0;
        @(posedge clk); #1;
        expq.push_back(model(ALU, 2'd0, 3'd0, 0));
        @(posedge clk); #1;
        expq.push_back(model(ALU, 2'd0, 3'd0, 0));
        @(posedge clk); #1;
        Rst = 1'b1;

        run_instr(ALU,  2'd0, 3'b000, -1, 0);
        run_instr(LD,   2'd0, 3'b000, -1, 0);
        run_instr(ST,   2'd0, 3'b000, -1, 0);
        run_instr(BR,   2'd1, 3'b010, -1, 0);
        run_instr(BR,   2'd1, 3'b000, -1, 0);
        run_instr(JAL,  2'd0, 3'b000, -1, 0);
        run_instr(LHI,  2'd0, 3'b000, -1, 0);
        run_instr(HLT,  2'd0, 3'b000, 21, 20);
        run_instr(5'b10101, 2'd0, 3'b000, -1, 0);
        run_instr(LD,   2'd0, 3'b000, 2, 0);
        run_instr(JR,   2'd0, 3'b000, -1, 0);

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 15))
                12:      rop = 5'($urandom_range(11, 30));
                13:      rop = HLT;
                default: rop = 5'($urandom_range(0, 10));
            endcase
            hc = (rop == HLT) ? int'($urandom_range(1, 5)) : 0;
            if (rop == HLT)                     ab = 1 + hc;
            else if ($urandom_range(0, 9) == 0) ab = int'($urandom_range(0, seq_len(rop) - 1));
            else                                ab = -1;
            run_instr(rop, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), ab, hc);
        end

        @(negedge clk); #1;
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL drain: got=%0d pending want=0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
